shift_seq_arbiter: RTL and testbench

Shares one single-bit logical right-shift step (x >> 1) between two requesters and sequences multi-bit shifts through it, one bit per clock. It accepts a data word and shift amount from the granted requester, iterates the shift step amount times, then returns the result with a one-cycle done pulse tagged with the owner. It sits between requester logic and the shared shift datapath, replacing replicated barrel shifters.

---
 rtl/shift_seq_arbiter.sv | 97 +++++++++
 tb/tb_shift_seq_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_seq_arbiter.sv
// shift_seq_arbiter: two-requester round-robin front end for a shared one-bit logical right shifter,
// iterating the shift once per clock and returning the result with a tagged done pulse.
module shift_seq_arbiter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic [AMT_W-1:0] amt0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  input  logic [AMT_W-1:0] amt1,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] result
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, result_q, result_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic last_q, last_d, owner_q, owner_d, gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic pick1;
  logic [WIDTH-1:0] sel_data;
  logic [AMT_W-1:0] sel_amt;
  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign pick1    = req1 & (~req0 | ~last_q);
  assign sel_data = pick1 ? data1 : data0;
  assign sel_amt  = pick1 ? amt1 : amt0;
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    result_d = result_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    case (state_q)
      IDLE: if (req0 | req1) begin
        gnt0_d  = ~pick1;
        gnt1_d  = pick1;
        shift_d = sel_data;
        cnt_d   = sel_amt;
        last_d  = pick1;
        if (sel_amt == '0) begin
          state_d  = DONE;
          result_d = sel_data;
          owner_d  = pick1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_d  = DONE;
          result_d = shift_q >> 1;
          owner_d  = last_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      result_q <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
    end
  end
  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign owner  = owner_q;
  assign result = result_q;
endmodule

// File: tb/tb_shift_seq_arbiter.sv
// tb_shift_seq_arbiter: directed checks of grant, latency, shift results, round-robin and async abort.
module tb_shift_seq_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic [2:0] amt0 = '0, amt1 = '0;
  logic gnt0, gnt1, busy, done, owner;
  logic [7:0] result;
  int n_chk = 0, n_fail = 0;
  int g, d, both, t, n, g0_again, dn;
  logic [7:0] rs [3];
  logic os [3], gs [3];
  logic [7:0] busy_res;

  shift_seq_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .data0(data0), .amt0(amt0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .amt1(amt1), .gnt1(gnt1),
    .busy(busy), .done(done), .owner(owner), .result(result)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic r, input logic [7:0] dat, input logic [2:0] a);
    if (r) begin req1 = 1'b1; data1 = dat; amt1 = a; end
    else begin req0 = 1'b1; data0 = dat; amt0 = a; end
    step();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp);
    int k = 0;
    while (!done && k < 20) begin step(); k++; end
    chk(tag, k, exp);
  endtask

  initial begin
    step();
    chk("rst_gnt0", gnt0, 0); chk("rst_gnt1", gnt1, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_owner", owner, 0); chk("rst_result", result, 0);
    rst_n = 1'b1;
    step();
    // single one-bit shift
    issue(0, 8'h99, 3'd1);
    chk("s1_gnt0", gnt0, 1); chk("s1_gnt1", gnt1, 0); chk("s1_busy", busy, 1); chk("s1_done0", done, 0);
    step();
    chk("s1_done", done, 1); chk("s1_res", result, 8'h4C); chk("s1_own", owner, 0);
    chk("s1_busy2", busy, 1); chk("s1_gnt_off", gnt0, 0);
    step();
    chk("s1_done_off", done, 0); chk("s1_idle", busy, 0); chk("s1_hold", result, 8'h4C);
    // multi-bit with zero fill
    issue(1, 8'h99, 3'd3);
    chk("s3_gnt1", gnt1, 1); chk("s3_gnt0", gnt0, 0);
    wait_done("s3_lat", 3);
    chk("s3_res", result, 8'h13); chk("s3_own", owner, 1);
    step();
    chk("s3_idle", busy, 0);
    issue(1, 8'hFF, 3'd7);
    wait_done("s7_lat", 7);
    chk("s7_res", result, 8'h01); chk("s7_own", owner, 1);
    step();
    // zero amount: done coincides with gnt
    issue(0, 8'hA5, 3'd0);
    chk("z_gnt0", gnt0, 1); chk("z_done", done, 1); chk("z_res", result, 8'hA5); chk("z_own", owner, 0);
    step();
    chk("z_done_off", done, 0); chk("z_idle", busy, 0);
    // round-robin from reset with both requests held
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req0 = 1'b1; data0 = 8'h80; amt0 = 3'd1;
    req1 = 1'b1; data1 = 8'h40; amt1 = 3'd2;
    g = 0; d = 0; both = 0; t = 0;
    while (d < 3 && t < 60) begin
      step(); t++;
      if (gnt0 && gnt1) both++;
      if ((gnt0 || gnt1) && g < 3) begin gs[g] = gnt1; g++; end
      if (done && d < 3) begin rs[d] = result; os[d] = owner; d++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_ndone", d, 3); chk("rr_cycles", t, 9); chk("rr_both", both, 0);
    chk("rr_g0", gs[0], 0); chk("rr_g1", gs[1], 1); chk("rr_g2", gs[2], 0);
    chk("rr_r0", rs[0], 8'h40); chk("rr_r1", rs[1], 8'h10); chk("rr_r2", rs[2], 8'h40);
    chk("rr_o0", os[0], 0); chk("rr_o1", os[1], 1); chk("rr_o2", os[2], 0);
    step(); step();
    chk("rr_idle", busy, 0);
    // request arriving while busy waits for IDLE
    req0 = 1'b1; data0 = 8'h33; amt0 = 3'd5;
    step();
    chk("bz_gnt0", gnt0, 1);
    req0 = 1'b0;
    step(); step();
    req1 = 1'b1; data1 = 8'h0C; amt1 = 3'd1;
    n = 0; g0_again = 0; busy_res = '0;
    while (!gnt1 && n < 20) begin
      step(); n++;
      if (gnt0) g0_again++;
      if (done) busy_res = result;
    end
    req1 = 1'b0;
    chk("bz_wait", n, 5); chk("bz_no_regnt0", g0_again, 0); chk("bz_first_res", busy_res, 8'h01);
    wait_done("bz_lat", 1);
    chk("bz_res", result, 8'h06); chk("bz_own", owner, 1);
    step(); step();
    // asynchronous reset mid-operation
    req0 = 1'b1; data0 = 8'hF0; amt0 = 3'd4;
    step();
    req0 = 1'b0;
    step();
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk("ar_busy", busy, 0); chk("ar_done", done, 0); chk("ar_res", result, 0);
    chk("ar_own", owner, 0); chk("ar_gnt0", gnt0, 0);
    step(); step();
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin step(); if (done) dn++; end
    chk("ar_no_done", dn, 0);
    issue(1, 8'h0F, 3'd1);
    chk("ar_gnt1", gnt1, 1);
    wait_done("ar_lat", 1);
    chk("ar_new_res", result, 8'h07); chk("ar_new_own", owner, 1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
